// File: rtl/logisim_clock_gen_multi_pkg.sv
// Shared definitions for the multi-channel clock generator: controller states,
// ClockBus bit positions and the config-channel select width.
package logisim_clock_gen_multi_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } ctrl_state_t;

    localparam int CB_CLK   = 0;
    localparam int CB_CLK_N = 1;
    localparam int CB_RISE  = 2;
    localparam int CB_FALL  = 3;
    localparam int CB_GCLK  = 4;
    localparam int CB_WIDTH = 5;

    // A single channel still needs a one-bit select so the port never vanishes.
    function automatic int ch_sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/logisim_clock_gen_multi_if.sv
// Control, config and clock-bus signals of the clock generator, bundled for the
// debug front-end (master) and the generator itself (slave).
interface logisim_clock_gen_multi_if #(
    parameter int NrOfChannels = 2,
    parameter int NrOfBits     = 8
);
    import logisim_clock_gen_multi_pkg::*;

    localparam int ChW = ch_sel_width(NrOfChannels);

    logic                               i_clock_tick;
    logic                               i_run;
    logic                               i_step_req;
    logic                               i_cfg_we;
    logic [ChW-1:0]                     i_cfg_channel;
    logic [NrOfBits-1:0]                i_cfg_high;
    logic [NrOfBits-1:0]                i_cfg_low;
    logic [CB_WIDTH*NrOfChannels-1:0]   o_clock_bus;
    logic                               o_running;
    logic                               o_step_done;

    modport master (
        output i_clock_tick, i_run, i_step_req, i_cfg_we, i_cfg_channel, i_cfg_high, i_cfg_low,
        input  o_clock_bus, o_running, o_step_done
    );

    modport slave (
        input  i_clock_tick, i_run, i_step_req, i_cfg_we, i_cfg_channel, i_cfg_high, i_cfg_low,
        output o_clock_bus, o_running, o_step_done
    );

endinterface

// File: rtl/logisim_clock_channel.sv
// One derived clock: tick counter, toggle, active/pending high-low config and the
// four registered ClockBus bits (clk, ~clk, rise strobe, fall strobe).
module logisim_clock_channel
    import logisim_clock_gen_multi_pkg::*;
#(
    parameter int NrOfBits     = 8,
    parameter int DefHighTicks = 1,
    parameter int DefLowTicks  = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_advance,
    input  logic                i_cfg_we,
    input  logic [NrOfBits-1:0] i_cfg_high,
    input  logic [NrOfBits-1:0] i_cfg_low,
    output logic [CB_FALL:0]    o_bus,
    output logic                o_fall_event
);

    localparam logic [NrOfBits-1:0] DEF_HIGH = NrOfBits'(DefHighTicks);
    localparam logic [NrOfBits-1:0] DEF_LOW  = NrOfBits'(DefLowTicks);
    localparam logic [NrOfBits-1:0] ONE      = NrOfBits'(1);

    logic [NrOfBits-1:0] r_cnt;
    logic                r_clk;
    logic [NrOfBits-1:0] r_act_high;
    logic [NrOfBits-1:0] r_act_low;
    logic [NrOfBits-1:0] r_pend_high;
    logic [NrOfBits-1:0] r_pend_low;
    logic                r_pend_valid;

    logic                w_wrap;
    logic                w_rise;
    logic                w_fall;
    logic [NrOfBits-1:0] w_next_high;
    logic [NrOfBits-1:0] w_high_load;
    logic [NrOfBits-1:0] w_low_load;

    assign w_wrap      = i_advance && (r_cnt == '0);
    assign w_rise      = w_wrap && !r_clk;
    assign w_fall      = w_wrap && r_clk;
    // Pending values take effect at the rise itself, so the high load already sees them.
    assign w_next_high = r_pend_valid ? r_pend_high : r_act_high;
    // A programmed count of 0 behaves like 1, i.e. a load of 0.
    assign w_high_load = (w_next_high == '0) ? '0 : w_next_high - ONE;
    assign w_low_load  = (r_act_low == '0) ? '0 : r_act_low - ONE;

    assign o_fall_event = w_fall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_clk        <= 1'b0;
            r_act_high   <= DEF_HIGH;
            r_act_low    <= DEF_LOW;
            r_pend_high  <= DEF_HIGH;
            r_pend_low   <= DEF_LOW;
            r_pend_valid <= 1'b0;
            o_bus        <= '0;
        end else begin
            if (w_rise) begin
                r_clk <= 1'b1;
                r_cnt <= w_high_load;
                if (r_pend_valid) begin
                    r_act_high   <= r_pend_high;
                    r_act_low    <= r_pend_low;
                    r_pend_valid <= 1'b0;
                end
            end else if (w_fall) begin
                r_clk <= 1'b0;
                r_cnt <= w_low_load;
            end else if (i_advance) begin
                r_cnt <= r_cnt - ONE;
            end

            // A write coinciding with the rise lands after the clear and waits for the next rise.
            if (i_cfg_we) begin
                r_pend_high  <= i_cfg_high;
                r_pend_low   <= i_cfg_low;
                r_pend_valid <= 1'b1;
            end

            o_bus[CB_CLK]   <= r_clk;
            o_bus[CB_CLK_N] <= ~r_clk;
            o_bus[CB_RISE]  <= w_rise;
            o_bus[CB_FALL]  <= w_fall;
        end
    end

endmodule

// File: rtl/logisim_clock_gen_multi.sv
// Multi-channel clock generator top: run/halt/single-step controller, config
// decode and one logisim_clock_channel per derived clock.
module logisim_clock_gen_multi
    import logisim_clock_gen_multi_pkg::*;
#(
    parameter int NrOfChannels = 2,
    parameter int NrOfBits     = 8,
    parameter int DefHighTicks = 1,
    parameter int DefLowTicks  = 1
) (
    input  logic                     i_global_clock,
    input  logic                     i_reset,
    logisim_clock_gen_multi_if.slave bus_if
);

    localparam int ChW = ch_sel_width(NrOfChannels);
    // Channels whose falling toggle completes a single step (channel 0 only).
    localparam logic [NrOfChannels-1:0] STEP_REF_MASK = NrOfChannels'(1);

    ctrl_state_t             r_state;
    logic                    r_running;
    logic                    r_step_done;
    logic                    w_advance;
    logic                    w_step_fall;
    logic [NrOfChannels-1:0] w_fall_event;

    assign w_advance   = bus_if.i_clock_tick && ((r_state == ST_RUN) || (r_state == ST_STEP));
    assign w_step_fall = |(w_fall_event & STEP_REF_MASK);

    assign bus_if.o_running   = r_running;
    assign bus_if.o_step_done = r_step_done;

    always_ff @(posedge i_global_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_HALT;
            r_running   <= 1'b0;
            r_step_done <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            case (r_state)
                ST_HALT: begin
                    if (bus_if.i_run) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end else if (bus_if.i_step_req) begin
                        r_state   <= ST_STEP;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!bus_if.i_run) begin
                        r_state   <= ST_HALT;
                        r_running <= 1'b0;
                    end
                end
                ST_STEP: begin
                    // Run outranks completion: going to RUN never reports a step.
                    if (bus_if.i_run) begin
                        r_state <= ST_RUN;
                    end else if (w_step_fall) begin
                        r_state     <= ST_HALT;
                        r_running   <= 1'b0;
                        r_step_done <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_HALT;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NrOfChannels; gi++) begin : g_ch
            logic [CB_FALL:0] w_bus;

            logisim_clock_channel #(
                .NrOfBits    (NrOfBits),
                .DefHighTicks(DefHighTicks),
                .DefLowTicks (DefLowTicks)
            ) u_channel (
                .i_clk       (i_global_clock),
                .i_rst       (i_reset),
                .i_advance   (w_advance),
                .i_cfg_we    (bus_if.i_cfg_we && (bus_if.i_cfg_channel == ChW'(gi))),
                .i_cfg_high  (bus_if.i_cfg_high),
                .i_cfg_low   (bus_if.i_cfg_low),
                .o_bus       (w_bus),
                .o_fall_event(w_fall_event[gi])
            );

            assign bus_if.o_clock_bus[CB_WIDTH*gi +: CB_FALL+1] = w_bus;
            assign bus_if.o_clock_bus[CB_WIDTH*gi + CB_GCLK]    = i_global_clock;
        end
    endgenerate

endmodule

// File: tb/tb_logisim_clock_gen_multi.sv
// Self-checking bench: hand-derived vector table for the default 2/3 clocks, then a
// scoreboard-fed reference model plus hand-written run/halt/step/reset corner cases.
module tb_logisim_clock_gen_multi;
    import logisim_clock_gen_multi_pkg::*;

    localparam int NCH   = 2;
    localparam int NB    = 8;
    localparam int DEF_H = 2;
    localparam int DEF_L = 3;
    localparam int CHW   = ch_sel_width(NCH);

    typedef struct {
        logic            tick;
        logic            run;
        logic            step;
        logic            we;
        logic [CHW-1:0]  ch;
        logic [NB-1:0]   high;
        logic [NB-1:0]   low;
    } in_t;

    typedef struct {
        logic [4*NCH-1:0] nib;
        logic             running;
        logic             sd;
    } exp_t;

    typedef struct {
        logic       run;
        logic       tick;
        logic [3:0] nib;
        logic       running;
        logic       sd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logisim_clock_gen_multi_if #(.NrOfChannels(NCH), .NrOfBits(NB)) bus_if ();

    logisim_clock_gen_multi #(
        .NrOfChannels(NCH),
        .NrOfBits    (NB),
        .DefHighTicks(DEF_H),
        .DefLowTicks (DEF_L)
    ) dut (
        .i_global_clock(clk),
        .i_reset       (rst),
        .bus_if        (bus_if)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb_q[$];
    vec_t tab[12];

    // Reference model state
    int         m_state;
    int         m_cnt[NCH];
    logic       m_clk[NCH];
    int         m_ah[NCH], m_al[NCH], m_ph[NCH], m_pl[NCH];
    logic       m_pv[NCH];
    logic [4*NCH-1:0] m_nib;
    logic       m_running, m_sd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [4*NCH-1:0] nibs();
        logic [4*NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[4*c +: 4] = bus_if.o_clock_bus[CB_WIDTH*c +: 4];
        return r;
    endfunction

    function automatic logic [NCH-1:0] gbits();
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = bus_if.o_clock_bus[CB_WIDTH*c + CB_GCLK];
        return r;
    endfunction

    function automatic logic bus_bit(input int c, input int b);
        return bus_if.o_clock_bus[CB_WIDTH*c + b];
    endfunction

    function automatic in_t mk(input logic tick, input logic run, input logic step);
        in_t v;
        v.tick = tick; v.run = run; v.step = step;
        v.we = 1'b0; v.ch = '0; v.high = '0; v.low = '0;
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_running = 1'b0; m_sd = 1'b0; m_nib = '0;
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_clk[c] = 1'b0; m_pv[c] = 1'b0;
            m_ah[c] = DEF_H; m_ph[c] = DEF_H; m_al[c] = DEF_L; m_pl[c] = DEF_L;
        end
    endtask

    task automatic model_step(input in_t v);
        logic adv, fall0, z;
        adv   = v.tick && (m_state != 0);
        fall0 = adv && (m_cnt[0] == 0) && m_clk[0];
        for (int c = 0; c < NCH; c++) begin
            z = adv && (m_cnt[c] == 0);
            m_nib[4*c +: 4] = {m_clk[c] & z, ~m_clk[c] & z, ~m_clk[c], m_clk[c]};
            if (z && !m_clk[c]) begin
                if (m_pv[c]) begin
                    m_ah[c] = m_ph[c]; m_al[c] = m_pl[c]; m_pv[c] = 1'b0;
                end
                m_cnt[c] = ((m_ah[c] == 0) ? 1 : m_ah[c]) - 1;
                m_clk[c] = 1'b1;
            end else if (z) begin
                m_cnt[c] = ((m_al[c] == 0) ? 1 : m_al[c]) - 1;
                m_clk[c] = 1'b0;
            end else if (adv) begin
                m_cnt[c] = m_cnt[c] - 1;
            end
            if (v.we && (int'(v.ch) == c)) begin
                m_ph[c] = int'(v.high); m_pl[c] = int'(v.low); m_pv[c] = 1'b1;
            end
        end
        m_sd = 1'b0;
        case (m_state)
            0: if (v.run) m_state = 1; else if (v.step) m_state = 2;
            1: if (!v.run) m_state = 0;
            default: if (v.run) m_state = 1; else if (fall0) begin m_state = 0; m_sd = 1'b1; end
        endcase
        m_running = (m_state != 0);
    endtask

    task automatic drive(input in_t v);
        bus_if.i_clock_tick  = v.tick;
        bus_if.i_run         = v.run;
        bus_if.i_step_req    = v.step;
        bus_if.i_cfg_we      = v.we;
        bus_if.i_cfg_channel = v.ch;
        bus_if.i_cfg_high    = v.high;
        bus_if.i_cfg_low     = v.low;
    endtask

    task automatic finish_cycle(input in_t v);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc=%0d tick=%b run=%b step=%b we=%b bus=%h running=%b step_done=%b",
                 cyc, v.tick, v.run, v.step, v.we, bus_if.o_clock_bus, bus_if.o_running, bus_if.o_step_done);
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: got 0 entries, required 1 (cycle %0d)", cyc);
        end else begin
            e = sb_q.pop_front();
            check("clock_bus", 32'(nibs()), 32'(e.nib));
            check("running", 32'(bus_if.o_running), 32'(e.running));
            check("step_done", 32'(bus_if.o_step_done), 32'(e.sd));
            check("gclk_pass", 32'(gbits()), 32'({NCH{1'b1}}));
        end
    endtask

    task automatic run_cycle(input in_t v);
        drive(v);
        model_step(v);
        sb_q.push_back('{nib: m_nib, running: m_running, sd: m_sd});
        finish_cycle(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t v;
        int  cnt_a, cnt_b, viol, r1, r2, found;

        // Channel 0/1 nibble {fall,rise,~clk,clk} after each edge, defaults 2/3, Run=1
        tab[0]  = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b0};
        tab[1]  = '{1'b1, 1'b1, 4'h6, 1'b1, 1'b0};
        tab[2]  = '{1'b1, 1'b1, 4'h1, 1'b1, 1'b0};
        tab[3]  = '{1'b1, 1'b1, 4'h9, 1'b1, 1'b0};
        tab[4]  = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b0};
        tab[5]  = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b0};
        tab[6]  = '{1'b1, 1'b1, 4'h6, 1'b1, 1'b0};
        tab[7]  = '{1'b1, 1'b1, 4'h1, 1'b1, 1'b0};
        tab[8]  = '{1'b1, 1'b1, 4'h9, 1'b1, 1'b0};
        tab[9]  = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b0};
        tab[10] = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b0};
        tab[11] = '{1'b1, 1'b1, 4'h6, 1'b1, 1'b0};

        drive(mk(1'b0, 1'b0, 1'b0));
        model_reset();
        @(posedge clk); #1;
        check("reset_bus", 32'(nibs()), 32'h0);
        check("reset_running", 32'(bus_if.o_running), 32'h0);
        check("reset_step_done", 32'(bus_if.o_step_done), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table: default 2/3 clocks on both channels
        for (int i = 0; i < 12; i++) begin
            v = mk(tab[i].tick, tab[i].run, 1'b0);
            drive(v);
            model_step(v);
            sb_q.push_back('{nib: {NCH{tab[i].nib}}, running: tab[i].running, sd: tab[i].sd});
            finish_cycle(v);
        end

        // Reconfigure ch1 to 1/1 during its high phase
        v = mk(1'b1, 1'b1, 1'b0);
        v.we = 1'b1; v.ch = CHW'(1); v.high = NB'(1); v.low = NB'(1);
        run_cycle(v);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 30; i++) begin
            run_cycle(mk(1'b1, 1'b1, 1'b0));
            if (i >= 20) begin
                cnt_a += int'(bus_bit(0, CB_RISE));
                cnt_b += int'(bus_bit(1, CB_RISE));
            end
        end
        check("ch0_rises_in_10", 32'(cnt_a), 32'd2);
        check("ch1_rises_in_10", 32'(cnt_b), 32'd5);

        // ClockTick every 4th cycle
        viol = 0; r1 = -1; r2 = -1;
        for (int i = 0; i < 48; i++) begin
            v = mk(((i % 4) == 3), 1'b1, 1'b0);
            run_cycle(v);
            for (int c = 0; c < NCH; c++)
                if (!v.tick && (bus_bit(c, CB_RISE) || bus_bit(c, CB_FALL))) viol++;
            if (v.tick && bus_bit(0, CB_RISE)) begin
                if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
            end
        end
        check("strobe_off_tick", 32'(viol), 32'd0);
        check("ch0_slow_period", 32'(r2 - r1), 32'd20);

        // Halt mid-high, then single-step to the fall
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            run_cycle(mk(1'b1, 1'b1, 1'b0));
            if (m_clk[0] && m_cnt[0] == 1) found = 1;
        end
        check("find_mid_high", 32'(found), 32'd1);
        run_cycle(mk(1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            run_cycle(mk(1'b1, 1'b0, 1'b0));
            check("halt_hold_ch0", 32'(nibs() & 8'h0F), 32'h1);
        end
        run_cycle(mk(1'b1, 1'b0, 1'b1));
        cnt_a = 0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(mk(1'b1, 1'b0, 1'b0));
            cnt_a += int'(bus_if.o_step_done);
        end
        check("step_done_pulses", 32'(cnt_a), 32'd1);
        check("step_halted", 32'(bus_if.o_running), 32'h0);
        check("step_ch0_low", 32'(bus_bit(0, CB_CLK)), 32'h0);

        // StepReq with Run=1 goes to RUN; second StepReq during STEP is ignored
        run_cycle(mk(1'b1, 1'b1, 1'b1));
        cnt_a = 0;
        for (int i = 0; i < 6; i++) begin
            run_cycle(mk(1'b1, 1'b1, 1'b0));
            cnt_a += int'(bus_if.o_step_done);
        end
        check("run_no_step_done", 32'(cnt_a), 32'd0);
        check("run_running", 32'(bus_if.o_running), 32'h1);
        run_cycle(mk(1'b1, 1'b0, 1'b0));
        run_cycle(mk(1'b1, 1'b0, 1'b1));
        cnt_a = 0;
        for (int i = 0; i < 14; i++) begin
            run_cycle(mk(1'b1, 1'b0, (i == 0)));
            cnt_a += int'(bus_if.o_step_done);
        end
        check("double_step_pulses", 32'(cnt_a), 32'd1);
        check("double_step_halted", 32'(bus_if.o_running), 32'h0);

        // Reset in the middle of a step
        run_cycle(mk(1'b1, 1'b0, 1'b1));
        drive(mk(1'b1, 1'b0, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        check("midstep_rst_running", 32'(bus_if.o_running), 32'h0);
        check("midstep_rst_bus", 32'(nibs()), 32'h0);
        check("midstep_rst_step_done", 32'(bus_if.o_step_done), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run_cycle(mk(1'b1, 1'b0, 1'b0));
        check("post_rst_bus", 32'(nibs()), 32'h22);
        cnt_a = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(mk(1'b1, 1'b0, 1'b0));
            cnt_a += int'(bus_if.o_step_done);
        end
        check("post_rst_no_step_done", 32'(cnt_a), 32'd0);

        // CfgHigh/CfgLow = 0 behave as 1
        v = mk(1'b1, 1'b0, 1'b0);
        v.we = 1'b1; v.ch = CHW'(0); v.high = '0; v.low = '0;
        run_cycle(v);
        cnt_a = 0;
        for (int i = 0; i < 16; i++) begin
            run_cycle(mk(1'b1, 1'b1, 1'b0));
            if (i >= 6) cnt_a += int'(bus_bit(0, CB_RISE));
        end
        check("zero_cfg_rises_in_10", 32'(cnt_a), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logisim_clock_gen_multi.md
# logisim_clock_gen_multi

Multi-channel successor of the single-channel Logisim clock component. It derives NrOfChannels independent clocks from GlobalClock and the ClockTick prescaler strobe, each with runtime-programmable high/low tick counts. A run/halt/single-step controller lets the debug front-end freeze the design or advance it by one master period. It sits at the top of the generated MCU design and feeds one 5-bit clock bus per clock domain.

## Interface
- NrOfChannels, 2: number of derived clocks.
- NrOfBits, 8: width of the tick counters and of the high/low config values.
- DefHighTicks, 1: high ticks loaded into every channel at reset.
- DefLowTicks, 1: low ticks loaded into every channel at reset.
- GlobalClock  in  1  sole clock.
- Reset  in  1  asynchronous, active-high reset.
- ClockTick  in  1  prescaler strobe; counters advance only when ClockTick=1.
- Run  in  1  level; 1 = free-run, 0 = halt.
- StepReq  in  1  one-cycle pulse; requests one master period while halted.
- CfgWe  in  1  config write strobe.
- CfgChannel  in  clog2(NrOfChannels), minimum 1  target channel.
- CfgHigh  in  NrOfBits  high ticks; 0 is treated as 1.
- CfgLow  in  NrOfBits  low ticks; 0 is treated as 1.
- ClockBus  out  5*NrOfChannels  per channel c, bits [5c+4:5c] = {GlobalClock, fall-strobe, rise-strobe, ~clk, clk}.
- Running  out  1  registered; 1 in RUN or STEP.
- StepDone  out  1  registered one-cycle pulse when a step completes.

## Operation
- Per channel: counter cnt, derived clock clk, active high/low values, pending high/low values, pending flag.
- An advance occurs when ClockTick=1 and the controller is in RUN or STEP. On an advance:
  - If cnt≠0: cnt decrements.
  - If cnt=0: clk toggles. On a low→high toggle cnt loads high-1. On a high→low toggle cnt loads low-1.
- Config write: CfgWe latches CfgHigh/CfgLow into the pending values of CfgChannel and sets the pending flag. Last write wins. CfgChannel ≥ NrOfChannels is ignored.
- The pending values become active only on that channel's low→high toggle, i.e. at a period boundary, so the high-1 load already uses the new value. This keeps phases glitch-free.
- Output registers per channel, each updated every GlobalClock cycle:
  - bit0 = clk
  - bit1 = ~clk
  - bit2 = ~clk & advance & cnt=0 (rise strobe)
  - bit3 = clk & advance & cnt=0 (fall strobe)
  - bit4 = GlobalClock, combinational pass-through.
- Controller FSM states are HALT, RUN and STEP; reset state is HALT.
  - HALT→RUN when Run=1.
  - HALT→STEP when Run=0 and StepReq=1.
  - RUN→HALT when Run=0. Counters and clocks freeze immediately and hold their levels.
  - STEP→RUN when Run=1. Run has priority over StepReq.
  - STEP→HALT on the advance in which channel 0 performs a high→low toggle. StepDone pulses in the following cycle.
  - StepReq is ignored in RUN and STEP.

## Timing
- Reset, asynchronous: cnt=0, clk=0, pending flags=0, active and pending values = DefHighTicks/DefLowTicks, state=HALT. ClockBus bits 0–3 per channel become 0,0,0,0 and must be re-registered to 0,1,0,0 on the first post-reset edge. Running=0, StepDone=0.
- clk and cnt change on the GlobalClock edge where the advance is seen. ClockBus bits 0–3 lag clk by one cycle.
- Rise/fall strobes appear one cycle before the corresponding bit0 change and last exactly one GlobalClock cycle.
- A config write in the same cycle as that channel's low→high toggle is not used for that toggle; it applies at the next one.
- Reset asserted mid-period or mid-step: everything returns immediately to reset values, and no StepDone is produced.
- Period per channel = (high+low) advances.

## Structure
- Shared package: FSM state encoding (HALT, RUN, STEP) and ClockBus bit-index constants (CLK, CLK_N, RISE, FALL, GCLK).
- One sub-module, logisim_clock_channel: counter, toggle, active/pending config and output registers. It is instantiated NrOfChannels times by a generate loop. The top level holds the controller FSM and config decode.

## Test plan
- Defaults 2/3, ClockTick=1, Run=1 after reset → channel 0 bit0 is high for 2 cycles and low for 3, period 5. The rise strobe occurs one cycle before each bit0 rise.
- Write ch1 = 1/1 during ch1's high phase → the current period finishes with the old values. From the next rise, ch1 toggles every advance. ch0 is unaffected.
- ClockTick high every 4th cycle → all toggles and strobes occur only in tick cycles, and the period is 4× longer.
- Run=0 mid-high → bit0 holds at 1, no strobes. A StepReq pulse → the channel completes to its fall, StepDone pulses once, and it stays halted.
- StepReq together with Run=1 → RUN, no StepDone. A second StepReq during STEP → ignored.
- Reset asserted mid-step → Running=0, bits 0–3 = 0,1,0,0 after one edge, no StepDone pulse. CfgHigh=0 → treated as 1.
